// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_pkg
//  Purpose  : Shared definitions for the hardwired control sequencer:
//             opcode constants, ALU function codes, sequencer state encoding,
//             the packed control word and small opcode helper functions.
//  Revision : 1.0  initial release
// ============================================================================
package control_pkg;

    localparam int c_OPW   = 5;     // opcode width, IR[31:27]
    localparam int c_ALUW  = 4;     // ALU function code width
    localparam int c_STW   = 4;     // state register width

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [c_OPW-1:0] c_OP_LD   = 5'b00000;
    localparam logic [c_OPW-1:0] c_OP_LDI  = 5'b00001;
    localparam logic [c_OPW-1:0] c_OP_ST   = 5'b00010;
    localparam logic [c_OPW-1:0] c_OP_ADD  = 5'b00011;
    localparam logic [c_OPW-1:0] c_OP_SUB  = 5'b00100;
    localparam logic [c_OPW-1:0] c_OP_AND  = 5'b00101;
    localparam logic [c_OPW-1:0] c_OP_OR   = 5'b00110;
    localparam logic [c_OPW-1:0] c_OP_SHR  = 5'b00111;
    localparam logic [c_OPW-1:0] c_OP_SHL  = 5'b01000;
    localparam logic [c_OPW-1:0] c_OP_ROR  = 5'b01001;
    localparam logic [c_OPW-1:0] c_OP_ROL  = 5'b01010;
    localparam logic [c_OPW-1:0] c_OP_ADDI = 5'b01011;
    localparam logic [c_OPW-1:0] c_OP_ANDI = 5'b01100;
    localparam logic [c_OPW-1:0] c_OP_ORI  = 5'b01101;
    localparam logic [c_OPW-1:0] c_OP_MUL  = 5'b01110;
    localparam logic [c_OPW-1:0] c_OP_DIV  = 5'b01111;
    localparam logic [c_OPW-1:0] c_OP_NEG  = 5'b10000;
    localparam logic [c_OPW-1:0] c_OP_NOT  = 5'b10001;
    localparam logic [c_OPW-1:0] c_OP_BR   = 5'b10010;
    localparam logic [c_OPW-1:0] c_OP_JR   = 5'b10011;
    localparam logic [c_OPW-1:0] c_OP_IN   = 5'b10100;
    localparam logic [c_OPW-1:0] c_OP_OUT  = 5'b10101;
    localparam logic [c_OPW-1:0] c_OP_MFHI = 5'b10110;
    localparam logic [c_OPW-1:0] c_OP_MFLO = 5'b10111;
    localparam logic [c_OPW-1:0] c_OP_NOP  = 5'b11000;
    localparam logic [c_OPW-1:0] c_OP_HALT = 5'b11001;

    // ------------------------------------------------------------------
    // ALU function codes
    // ------------------------------------------------------------------
    localparam logic [c_ALUW-1:0] c_ALU_ADD = 4'd0;
    localparam logic [c_ALUW-1:0] c_ALU_SUB = 4'd1;
    localparam logic [c_ALUW-1:0] c_ALU_AND = 4'd2;
    localparam logic [c_ALUW-1:0] c_ALU_OR  = 4'd3;
    localparam logic [c_ALUW-1:0] c_ALU_SHR = 4'd4;
    localparam logic [c_ALUW-1:0] c_ALU_SHL = 4'd5;
    localparam logic [c_ALUW-1:0] c_ALU_ROR = 4'd6;
    localparam logic [c_ALUW-1:0] c_ALU_ROL = 4'd7;
    localparam logic [c_ALUW-1:0] c_ALU_MUL = 4'd8;
    localparam logic [c_ALUW-1:0] c_ALU_DIV = 4'd9;
    localparam logic [c_ALUW-1:0] c_ALU_NEG = 4'd10;
    localparam logic [c_ALUW-1:0] c_ALU_NOT = 4'd11;

    // ------------------------------------------------------------------
    // Sequencer states. T0..T7 are consecutive so the sequencer can
    // advance by incrementing.
    // ------------------------------------------------------------------
    typedef enum logic [c_STW-1:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Control word driven into the datapath
    // ------------------------------------------------------------------
    typedef struct packed {
        logic               pc_out;
        logic               zhi_out;
        logic               zlow_out;
        logic               mdr_out;
        logic               hi_out;
        logic               lo_out;
        logic               inport_out;
        logic               c_out;
        logic               ba_out;
        logic               r_out;
        logic               mar_in;
        logic               z_in;
        logic               pc_in;
        logic               mdr_in;
        logic               ir_in;
        logic               y_in;
        logic               hi_in;
        logic               lo_in;
        logic               outport_in;
        logic               r_in;
        logic               con_in;
        logic               gra;
        logic               grb;
        logic               grc;
        logic               inc_pc;
        logic               read;
        logic               write;
        logic [c_ALUW-1:0]  alu_op;
        logic               run;
    } ctrl_t;

    localparam int c_CTRLW = $bits(ctrl_t);

    // ALU function an opcode asks for in its compute step.
    function automatic logic [c_ALUW-1:0] alu_sel(input logic [c_OPW-1:0] op);
        logic [c_ALUW-1:0] f;
        case (op)
            c_OP_SUB:             f = c_ALU_SUB;
            c_OP_AND, c_OP_ANDI:  f = c_ALU_AND;
            c_OP_OR,  c_OP_ORI:   f = c_ALU_OR;
            c_OP_SHR:             f = c_ALU_SHR;
            c_OP_SHL:             f = c_ALU_SHL;
            c_OP_ROR:             f = c_ALU_ROR;
            c_OP_ROL:             f = c_ALU_ROL;
            c_OP_MUL:             f = c_ALU_MUL;
            c_OP_DIV:             f = c_ALU_DIV;
            c_OP_NEG:             f = c_ALU_NEG;
            c_OP_NOT:             f = c_ALU_NOT;
            default:              f = c_ALU_ADD;
        endcase
        return f;
    endfunction

    // Final micro-step of each opcode. Undefined opcodes behave as nop.
    function automatic state_t last_step(input logic [c_OPW-1:0] op);
        state_t s;
        case (op)
            c_OP_JR, c_OP_IN, c_OP_OUT, c_OP_MFHI, c_OP_MFLO:
                s = S_T3;
            c_OP_NEG, c_OP_NOT:
                s = S_T4;
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHL,
            c_OP_ROR, c_OP_ROL, c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LDI:
                s = S_T5;
            c_OP_MUL, c_OP_DIV, c_OP_BR:
                s = S_T6;
            c_OP_LD, c_OP_ST:
                s = S_T7;
            default:
                s = S_T2;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
//  Module   : control_decode
//  Purpose  : Purely combinational decode of {state, opcode, CON_FF} into the
//             datapath control word.
//  Ports    : state_i   - current sequencer state (state_t encoding)
//             opcode_i  - IR[31:27]
//             con_ff_i  - branch-condition flag
//             ctrl_o    - packed control word (ctrl_t)
//  Revision : 1.0  initial release
// ============================================================================
import control_pkg::*;

module control_decode (
    input  logic [c_STW-1:0]   state_i,
    input  logic [c_OPW-1:0]   opcode_i,
    input  logic               con_ff_i,
    output logic [c_CTRLW-1:0] ctrl_o
);

    ctrl_t  w_c;
    state_t w_state;

    assign w_state = state_t'(state_i);
    assign ctrl_o  = w_c;

    always_comb begin
        w_c        = '0;
        w_c.run    = 1'b1;
        w_c.alu_op = c_ALU_ADD;

        case (w_state)
            // ---------------- fetch ----------------
            S_T0: begin
                w_c.pc_out = 1'b1;
                w_c.mar_in = 1'b1;
                w_c.inc_pc = 1'b1;
                w_c.z_in   = 1'b1;
            end
            S_T1: begin
                w_c.zlow_out = 1'b1;
                w_c.pc_in    = 1'b1;
                w_c.read     = 1'b1;
                w_c.mdr_in   = 1'b1;
            end
            S_T2: begin
                w_c.mdr_out = 1'b1;
                w_c.ir_in   = 1'b1;
            end

            // ---------------- execute ----------------
            S_T3: begin
                case (opcode_i)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHL,
                    c_OP_ROR, c_OP_ROL, c_OP_ADDI, c_OP_ANDI, c_OP_ORI: begin
                        w_c.grb   = 1'b1;
                        w_c.r_out = 1'b1;
                        w_c.y_in  = 1'b1;
                    end
                    c_OP_NEG, c_OP_NOT: begin
                        w_c.grb    = 1'b1;
                        w_c.r_out  = 1'b1;
                        w_c.alu_op = alu_sel(opcode_i);
                        w_c.z_in   = 1'b1;
                    end
                    c_OP_MUL, c_OP_DIV: begin
                        w_c.gra   = 1'b1;
                        w_c.r_out = 1'b1;
                        w_c.y_in  = 1'b1;
                    end
                    c_OP_LD, c_OP_LDI, c_OP_ST: begin
                        // Base register, or zero when Rb is R0, via BAout.
                        w_c.grb    = 1'b1;
                        w_c.ba_out = 1'b1;
                        w_c.y_in   = 1'b1;
                    end
                    c_OP_BR: begin
                        w_c.gra    = 1'b1;
                        w_c.r_out  = 1'b1;
                        w_c.con_in = 1'b1;
                    end
                    c_OP_JR: begin
                        w_c.gra   = 1'b1;
                        w_c.r_out = 1'b1;
                        w_c.pc_in = 1'b1;
                    end
                    c_OP_IN: begin
                        w_c.inport_out = 1'b1;
                        w_c.gra        = 1'b1;
                        w_c.r_in       = 1'b1;
                    end
                    c_OP_OUT: begin
                        w_c.gra        = 1'b1;
                        w_c.r_out      = 1'b1;
                        w_c.outport_in = 1'b1;
                    end
                    c_OP_MFHI: begin
                        w_c.hi_out = 1'b1;
                        w_c.gra    = 1'b1;
                        w_c.r_in   = 1'b1;
                    end
                    c_OP_MFLO: begin
                        w_c.lo_out = 1'b1;
                        w_c.gra    = 1'b1;
                        w_c.r_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opcode_i)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHL,
                    c_OP_ROR, c_OP_ROL: begin
                        w_c.grc    = 1'b1;
                        w_c.r_out  = 1'b1;
                        w_c.alu_op = alu_sel(opcode_i);
                        w_c.z_in   = 1'b1;
                    end
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI: begin
                        w_c.c_out  = 1'b1;
                        w_c.alu_op = alu_sel(opcode_i);
                        w_c.z_in   = 1'b1;
                    end
                    c_OP_NEG, c_OP_NOT: begin
                        w_c.zlow_out = 1'b1;
                        w_c.gra      = 1'b1;
                        w_c.r_in     = 1'b1;
                    end
                    c_OP_MUL, c_OP_DIV: begin
                        w_c.grb    = 1'b1;
                        w_c.r_out  = 1'b1;
                        w_c.alu_op = alu_sel(opcode_i);
                        w_c.z_in   = 1'b1;
                    end
                    c_OP_LD, c_OP_LDI, c_OP_ST: begin
                        // Effective address = base + C, using the default ADD.
                        w_c.c_out = 1'b1;
                        w_c.z_in  = 1'b1;
                    end
                    c_OP_BR: begin
                        w_c.pc_out = 1'b1;
                        w_c.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode_i)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHL,
                    c_OP_ROR, c_OP_ROL, c_OP_ADDI, c_OP_ANDI, c_OP_ORI,
                    c_OP_LDI: begin
                        w_c.zlow_out = 1'b1;
                        w_c.gra      = 1'b1;
                        w_c.r_in     = 1'b1;
                    end
                    c_OP_MUL, c_OP_DIV: begin
                        w_c.zlow_out = 1'b1;
                        w_c.lo_in    = 1'b1;
                    end
                    c_OP_LD, c_OP_ST: begin
                        w_c.zlow_out = 1'b1;
                        w_c.mar_in   = 1'b1;
                    end
                    c_OP_BR: begin
                        w_c.c_out = 1'b1;
                        w_c.z_in  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode_i)
                    c_OP_MUL, c_OP_DIV: begin
                        w_c.zhi_out = 1'b1;
                        w_c.hi_in   = 1'b1;
                    end
                    c_OP_LD: begin
                        w_c.read   = 1'b1;
                        w_c.mdr_in = 1'b1;
                    end
                    c_OP_ST: begin
                        // Read stays low so MDR takes the bus, not memory.
                        w_c.gra    = 1'b1;
                        w_c.r_out  = 1'b1;
                        w_c.mdr_in = 1'b1;
                    end
                    c_OP_BR: begin
                        // Branch target is always on the bus; CON_FF decides
                        // whether PC actually takes it.
                        w_c.zlow_out = 1'b1;
                        w_c.pc_in    = con_ff_i;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opcode_i)
                    c_OP_LD: begin
                        w_c.mdr_out = 1'b1;
                        w_c.gra     = 1'b1;
                        w_c.r_in    = 1'b1;
                    end
                    c_OP_ST: begin
                        w_c.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                w_c.run = 1'b0;
            end
            default: ;      // S_RST: all controls low, Run high
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Hardwired Moore control sequencer for the single-bus datapath.
//             Holds the state register and next-state logic; control outputs
//             are a pure decode of {state, IR[31:27], CON_FF}.
//  Ports    : Clock, Clear (async, active-high), IR, CON_FF, Stop in;
//             bus-drive enables, register-load enables, Gra/Grb/Grc,
//             IncPC/Read/Write, AluOp and Run out.
//  Revision : 1.0  initial release
// ============================================================================
import control_pkg::*;

module control_unit #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
    input  logic            Stop,
    output logic            PCout,
    output logic            Zhiout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            HIout,
    output logic            LOout,
    output logic            InPortout,
    output logic            Cout,
    output logic            BAout,
    output logic            Rout,
    output logic            MARin,
    output logic            Zin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic            OutPortin,
    output logic            Rin,
    output logic            CONin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            IncPC,
    output logic            Read,
    output logic            Write,
    output logic [ALUW-1:0] AluOp,
    output logic            Run
);

    state_t            state_q;
    state_t            state_d;
    logic [OPW-1:0]    w_opcode;
    ctrl_t             w_ctrl;
    logic              w_unused_ir;

    assign w_opcode    = IR[31 -: OPW];
    assign w_unused_ir = ^IR[31-OPW:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state. The end-of-instruction test at T2 uses the IR as
    // presented; later steps cannot end nop/halt, so IR only steers the
    // sequence from that point on.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_q == last_step(w_opcode)) begin
                    if (w_opcode == c_OP_HALT || Stop) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_T0;
                    end
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            S_HALT: state_d = S_HALT;   // only Clear leaves HALT
            default: state_d = S_RST;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    control_decode u_decode (
        .state_i  (state_q),
        .opcode_i (w_opcode),
        .con_ff_i (CON_FF),
        .ctrl_o   (w_ctrl)
    );

    assign PCout     = w_ctrl.pc_out;
    assign Zhiout    = w_ctrl.zhi_out;
    assign Zlowout   = w_ctrl.zlow_out;
    assign MDRout    = w_ctrl.mdr_out;
    assign HIout     = w_ctrl.hi_out;
    assign LOout     = w_ctrl.lo_out;
    assign InPortout = w_ctrl.inport_out;
    assign Cout      = w_ctrl.c_out;
    assign BAout     = w_ctrl.ba_out;
    assign Rout      = w_ctrl.r_out;
    assign MARin     = w_ctrl.mar_in;
    assign Zin       = w_ctrl.z_in;
    assign PCin      = w_ctrl.pc_in;
    assign MDRin     = w_ctrl.mdr_in;
    assign IRin      = w_ctrl.ir_in;
    assign Yin       = w_ctrl.y_in;
    assign HIin      = w_ctrl.hi_in;
    assign LOin      = w_ctrl.lo_in;
    assign OutPortin = w_ctrl.outport_in;
    assign Rin       = w_ctrl.r_in;
    assign CONin     = w_ctrl.con_in;
    assign Gra       = w_ctrl.gra;
    assign Grb       = w_ctrl.grb;
    assign Grc       = w_ctrl.grc;
    assign IncPC     = w_ctrl.inc_pc;
    assign Read      = w_ctrl.read;
    assign Write     = w_ctrl.write;
    assign AluOp     = ALUW'(w_ctrl.alu_op);
    assign Run       = w_ctrl.run;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Self-checking bench for control_unit. A step-level model
//             written from the micro-step tables checks every cycle;
//             directed runs add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, Rin, CONin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [3:0] AluOp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clock = ~Clock;

    control_unit #(.OPW(5), .ALUW(4)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .OutPortin(OutPortin), .Rin(Rin), .CONin(CONin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .AluOp(AluOp),
        .Run(Run)
    );

    // Bit i of dut_bits carries the signal named c_names[i].
    string c_names [27] = '{"PCout","Zhiout","Zlowout","MDRout","HIout","LOout",
        "InPortout","Cout","BAout","Rout","MARin","Zin","PCin","MDRin","IRin",
        "Yin","HIin","LOin","OutPortin","Rin","CONin","Gra","Grb","Grc",
        "IncPC","Read","Write"};
    logic [26:0] dut_bits;
    assign dut_bits = {Write, Read, IncPC, Grc, Grb, Gra, CONin, Rin, OutPortin,
                       LOin, HIin, Yin, IRin, MDRin, PCin, Zin, MARin, Rout,
                       BAout, Cout, InPortout, LOout, HIout, MDRout, Zlowout,
                       Zhiout, PCout};

    // ------------------------------------------------------------------
    // Model: instruction lengths, micro-step text and ALU functions
    // ------------------------------------------------------------------
    function automatic int instr_len(input logic [4:0] op);
        case (op)
            5'd19, 5'd20, 5'd21, 5'd22, 5'd23:                return 4;
            5'd16, 5'd17:                                      return 5;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
            5'd11, 5'd12, 5'd13, 5'd1:                         return 6;
            5'd14, 5'd15, 5'd18:                               return 7;
            5'd0, 5'd2:                                        return 8;
            default:                                           return 3;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd4:         return 4'd1;
            5'd5, 5'd12:  return 4'd2;
            5'd6, 5'd13:  return 4'd3;
            5'd7:         return 4'd4;
            5'd8:         return 4'd5;
            5'd9:         return 4'd6;
            5'd10:        return 4'd7;
            5'd14:        return 4'd8;
            5'd15:        return 4'd9;
            5'd16:        return 4'd10;
            5'd17:        return 4'd11;
            default:      return 4'd0;
        endcase
    endfunction

    // "ALU" = the opcode's ALU function; "PCinC" = PCin follows CON_FF.
    function automatic string step_text(input logic [4:0] op, input int st);
        if (st == 0) return "PCout MARin IncPC Zin";
        if (st == 1) return "Zlowout PCin Read MDRin";
        if (st == 2) return "MDRout IRin";
        if (op >= 5'd3 && op <= 5'd13) begin
            if (st == 3) return "Grb Rout Yin";
            if (st == 4) return (op >= 5'd11) ? "Cout ALU Zin" : "Grc Rout ALU Zin";
            if (st == 5) return "Zlowout Gra Rin";
        end
        case (op)
            5'd16, 5'd17: case (st)
                3: return "Grb Rout ALU Zin";
                4: return "Zlowout Gra Rin";
                default: return "";
            endcase
            5'd14, 5'd15: case (st)
                3: return "Gra Rout Yin";
                4: return "Grb Rout ALU Zin";
                5: return "Zlowout LOin";
                6: return "Zhiout HIin";
                default: return "";
            endcase
            5'd0, 5'd1, 5'd2: case (st)
                3: return "Grb BAout Yin";
                4: return "Cout Zin";
                5: return (op == 5'd1) ? "Zlowout Gra Rin" : "Zlowout MARin";
                6: return (op == 5'd0) ? "Read MDRin" : "Gra Rout MDRin";
                7: return (op == 5'd0) ? "MDRout Gra Rin" : "Write";
                default: return "";
            endcase
            5'd18: case (st)
                3: return "Gra Rout CONin";
                4: return "PCout Yin";
                5: return "Cout Zin";
                6: return "Zlowout PCinC";
                default: return "";
            endcase
            5'd19: return (st == 3) ? "Gra Rout PCin" : "";
            5'd20: return (st == 3) ? "InPortout Gra Rin" : "";
            5'd21: return (st == 3) ? "Gra Rout OutPortin" : "";
            5'd22: return (st == 3) ? "HIout Gra Rin" : "";
            5'd23: return (st == 3) ? "LOout Gra Rin" : "";
            default: return "";
        endcase
    endfunction

    function automatic int idx(input string nm);
        for (int i = 0; i < 27; i++) if (c_names[i] == nm) return i;
        return 0;
    endfunction

    // step: -1 reset, 0..7 = T0..T7, 8 = HALT
    task automatic model_exp(input int st, input logic [4:0] op, input logic con,
                             output logic [26:0] bits, output logic [3:0] alu,
                             output logic run);
        string txt, tok;
        int    s0;
        bits = '0; alu = 4'd0; run = 1'b1;
        if (st == 8) run = 1'b0;
        else if (st >= 0) begin
            txt = {step_text(op, st), " "};
            s0  = 0;
            for (int i = 0; i < txt.len(); i++) begin
                if (txt[i] == 8'h20) begin
                    if (i > s0) begin
                        tok = txt.substr(s0, i - 1);
                        if (tok == "ALU") alu = alu_of(op);
                        else if (tok == "PCinC") bits[idx("PCin")] = con;
                        else bits[idx(tok)] = 1'b1;
                    end
                    s0 = i + 1;
                end
            end
        end
    endtask

    int m_step = -1;
    always @(posedge Clock or posedge Clear) begin
        if (Clear) m_step <= -1;
        else if (m_step == -1) m_step <= 0;
        else if (m_step == 8) m_step <= 8;
        else if (m_step == instr_len(IR[31:27]) - 1)
            m_step <= (IR[31:27] == 5'd25 || Stop) ? 8 : 0;
        else m_step <= m_step + 1;
    end

    // Per-cycle compare against the model.
    always @(negedge Clock) begin
        logic [26:0] eb;
        logic [3:0]  ea;
        logic        er;
        if (!Clear) begin
            model_exp(m_step, IR[31:27], CON_FF, eb, ea, er);
            n_checks++;
            if (dut_bits !== eb || AluOp !== ea || Run !== er) begin
                n_errors++;
                $display("FAIL cycle step=%0d op=%b: got bits=%h alu=%0d run=%b, expected bits=%h alu=%0d run=%b",
                         m_step, IR[31:27], dut_bits, AluOp, Run, eb, ea, er);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    logic [26:0] h_bits [0:9];
    logic [3:0]  h_alu  [0:9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Called at the negedge of T0; records each step and counts cycles
    // until the next T0.
    task automatic run_instr(input string nm, input logic [31:0] ir,
                             input logic con, input int exp_len);
        int n = 0;
        bit done = 0;
        IR = ir; CON_FF = con;
        h_bits[0] = dut_bits; h_alu[0] = AluOp;
        while (!done && n < 40) begin
            @(negedge Clock);
            n++;
            if (PCout && MARin && IncPC) done = 1;
            else if (n < 10) begin h_bits[n] = dut_bits; h_alu[n] = AluOp; end
        end
        chk({nm, " length"}, n, exp_len);
    endtask

    typedef struct { logic [31:0] ir; int len; } vec_t;
    vec_t tbl [20] = '{
        '{32'h18A50123, 6}, '{32'h20A50123, 6}, '{32'h28A50123, 6}, '{32'h30A50123, 6},
        '{32'h38A50123, 6}, '{32'h40A50123, 6}, '{32'h48A50123, 6}, '{32'h50A50123, 6},
        '{32'h58A50123, 6}, '{32'h68A50123, 6}, '{32'h78A50123, 5 + 2}, '{32'h80A50123, 5},
        '{32'h88A50123, 5}, '{32'h98A50123, 4}, '{32'hA0A50123, 4}, '{32'hA8A50123, 4},
        '{32'hB0A50123, 4}, '{32'hB8A50123, 4}, '{32'hC0A50123, 3}, '{32'hF8A50123, 3}};

    initial begin
        #1 Clear = 1'b1;
        @(negedge Clock);
        chk("reset controls", {5'd0, dut_bits}, 32'h0);
        chk("reset AluOp", AluOp, 0);
        chk("reset Run", Run, 1);
        Clear = 1'b0;
        @(negedge Clock);              // RST -> T0 on first edge

        // andi R2,R1,26
        run_instr("andi", 32'h6108001A, 1'b0, 6);
        chk("fetch T0", h_bits[0], 32'h1000C01);
        chk("fetch T1", h_bits[1], 32'h2003004);
        chk("fetch T2", h_bits[2], 32'h4008);
        chk("andi T3",  h_bits[3], 32'h408200);
        chk("andi T4",  h_bits[4], 32'h880);
        chk("andi T4 AluOp", h_alu[4], 2);
        chk("andi T5",  h_bits[5], 32'h280004);

        run_instr("ld", 32'h00800010, 1'b0, 8);
        chk("ld T5", h_bits[5], 32'h404);
        chk("ld T6", h_bits[6], 32'h2002000);
        chk("ld T7", h_bits[7], 32'h280008);
        run_instr("st", 32'h10880000, 1'b0, 8);
        chk("st T6", h_bits[6], 32'h202200);
        chk("st T7", h_bits[7], 32'h4000000);

        run_instr("br0", 32'h90800005, 1'b0, 7);
        chk("br CON_FF=0 T6", h_bits[6], 32'h4);
        run_instr("br1", 32'h90800005, 1'b1, 7);
        chk("br CON_FF=1 T6", h_bits[6], 32'h1004);

        run_instr("mul", 32'h70880000, 1'b0, 7);
        chk("mul T4 AluOp", h_alu[4], 8);
        chk("mul T5", h_bits[5], 32'h20004);
        chk("mul T6", h_bits[6], 32'h10002);

        run_instr("ldi", 32'h08800007, 1'b0, 6);
        foreach (tbl[i]) run_instr("table", tbl[i].ir, i[0], tbl[i].len);

        // Stop held from T3 of add: finishes T5, then HALT.
        IR = 32'h18A50123;
        repeat (3) @(negedge Clock);
        Stop = 1'b1;
        repeat (3) @(negedge Clock);
        for (int k = 0; k < 20; k++) begin
            chk("halt controls", {5'd0, dut_bits}, 32'h0);
            chk("halt Run", Run, 0);
            @(negedge Clock);
        end
        Clear = 1'b1;
        @(negedge Clock);
        Stop = 1'b0;
        Clear = 1'b0;
        @(negedge Clock);
        chk("restart T0 after halt", {PCout, MARin, IncPC, Zin, Run}, 5'b11111);

        // Clear during T4 of ld, between edges.
        IR = 32'h00800010;
        repeat (4) @(negedge Clock);
        chk("ld T4 before clear", {Cout, Zin}, 2'b11);
        #2 Clear = 1'b1;
        #1;
        chk("mid-cycle clear controls", {5'd0, dut_bits}, 32'h0);
        chk("mid-cycle clear AluOp/Run", {AluOp, Run}, 5'b00001);
        @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);
        run_instr("nop after clear", 32'hC0000000, 1'b0, 3);

        // halt opcode
        IR = 32'hC8000000;
        repeat (2) @(negedge Clock);
        chk("halt op T2 Run", Run, 1);
        @(negedge Clock);
        chk("halt op after T2 Run", Run, 0);
        repeat (3) @(negedge Clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
